// File: rtl/dispatch_queue.sv
// dispatch_queue: circular fetch-to-dispatch instruction buffer; define DQ_STALL_CNT_EN to enable the stall_cnt counter
module dispatch_queue #(
  parameter int N_WAY    = 2,
  parameter int DQ_DEPTH = 8,
  parameter int XLEN     = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_WAY-1:0]                    fetch_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]          fetch_inst,
  input  logic [N_WAY-1:0][XLEN-1:0]          fetch_pc,
  input  logic [N_WAY-1:0][XLEN-1:0]          fetch_npc,
  output logic                                fetch_ready,
  output logic [N_WAY-1:0][3*XLEN+15:0]       dispatch_packet,
  output logic [N_WAY-1:0]                    branch_inst,
  input  logic [N_WAY-1:0]                    dispatched,
  input  logic                                take_branch,
  output logic [$clog2(DQ_DEPTH):0]           dq_count,
  output logic [31:0]                         stall_cnt
);
  localparam int AW = $clog2(DQ_DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] inst_q [DQ_DEPTH];
  logic [XLEN-1:0] pc_q   [DQ_DEPTH];
  logic [XLEN-1:0] npc_q  [DQ_DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, enq, deq;
  logic run, enq_ok;
  assign dq_count    = count_q;
  assign fetch_ready = (CW'(DQ_DEPTH) - count_q) >= CW'(N_WAY);
  assign enq_ok      = fetch_ready && !take_branch;
  always_comb begin
    enq = '0;
    deq = '0;
    run = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      enq = enq + CW'(fetch_valid[i]);
      run = run & dispatched[i] & (CW'(i) < count_q);
      deq = deq + CW'(run);
    end
    enq     = enq_ok ? enq : '0;
    head_d  = take_branch ? '0 : head_q + AW'(deq);
    tail_d  = take_branch ? '0 : tail_q + AW'(enq);
    count_d = take_branch ? '0 : count_q + enq - deq;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Payload needs no reset: lanes beyond dq_count are masked to zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (enq_ok && fetch_valid[i]) begin
        inst_q[tail_q + AW'(i)] <= fetch_inst[i];
        pc_q[tail_q + AW'(i)]   <= fetch_pc[i];
        npc_q[tail_q + AW'(i)]  <= fetch_npc[i];
      end
    end
  end
  // Packet layout, MSB first: valid, inst, pc, npc, src1, src2, dest.
  for (genvar g = 0; g < N_WAY; g++) begin : g_lane
    logic [AW-1:0]   idx;
    logic            v;
    logic [XLEN-1:0] ins;
    logic [6:0]      op;
    logic [4:0]      src1, dest;
    assign idx  = head_q + AW'(g);
    assign v    = CW'(g) < count_q;
    assign ins  = v ? inst_q[idx] : '0;
    assign op   = ins[6:0];
    assign src1 = (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) ? 5'd0 : ins[19:15];
    assign dest = (op == 7'b1100011 || op == 7'b0100011) ? 5'd0 : ins[11:7];
    assign branch_inst[g]     = v && op == 7'b1100011;
    assign dispatch_packet[g] = v ? {1'b1, ins, pc_q[idx], npc_q[idx], src1, ins[24:20], dest} : '0;
  end
`ifdef DQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d   = (count_q != '0 && !dispatched[0] && !take_branch && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule
